// File: rtl/mega_wb_pkg.sv
// Shared types and constants for the XMEGA ALU writeback stage.
package mega_wb_pkg;

    localparam int unsigned SREG_W = 8;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DATA_W = 16;

    localparam int unsigned SREG_C = 0;
    localparam int unsigned SREG_Z = 1;
    localparam int unsigned SREG_N = 2;
    localparam int unsigned SREG_V = 3;
    localparam int unsigned SREG_S = 4;
    localparam int unsigned SREG_H = 5;
    localparam int unsigned SREG_T = 6;
    localparam int unsigned SREG_I = 7;

    localparam logic [5:0] SREG_IO_ADDR = 6'h3F;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_LO   = 2'd1,
        WB_HI   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/mega_sreg.sv
// Architectural status register with io / alu / int_ack / reti priority merge.
module mega_sreg
    import mega_wb_pkg::*;
#(
    parameter logic [7:0] SREG_RST = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              io_we,
    input  logic [SREG_W-1:0] io_wdata,
    input  logic              alu_we,
    input  logic [SREG_W-1:0] alu_flags,
    input  logic              int_ack,
    input  logic              reti,
    output logic [SREG_W-1:0] sreg
);

    logic [SREG_W-1:0] sreg_d;

    // A bus write replaces the whole register; I is then overridden by interrupt entry/exit.
    always_comb begin
        sreg_d = sreg;
        if (io_we) begin
            sreg_d = io_wdata;
        end else if (alu_we) begin
            sreg_d = alu_flags;
        end
        if (int_ack) begin
            sreg_d[SREG_I] = 1'b0;
        end else if (reti) begin
            sreg_d[SREG_I] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= SREG_RST;
        end else begin
            sreg <= sreg_d;
        end
    end

endmodule

// File: rtl/mega_alu_wb.sv
// ALU writeback: serialises 8/16-bit results onto the byte-wide register-file
// write port and owns SREG.
module mega_alu_wb
    import mega_wb_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter logic [7:0]  SREG_RST   = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd_addr,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic                  alu_wide,
    input  logic                  alu_wr_rd,
    input  logic                  alu_flag_wr,
    input  logic [SREG_W-1:0]     alu_flags,
    input  logic                  io_sreg_we,
    input  logic [SREG_W-1:0]     io_sreg_wdata,
    input  logic                  int_ack,
    input  logic                  reti,
    output logic [SREG_W-1:0]     sreg,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_addr,
    output logic [BYTE_W-1:0]     rf_data
);

    wb_state_t             state_q, state_d;
    logic                  accept_c, load_c;
    logic                  rf_we_d, ready_d;
    logic [REG_ADDR_W-1:0] rf_addr_d, hi_addr_q, hi_addr_d;
    logic [BYTE_W-1:0]     rf_data_d, hi_data_q, hi_data_d;
    logic                  wide_q, wide_d;

    assign accept_c = alu_valid & alu_ready;
    assign load_c   = accept_c & alu_wr_rd;

    // Next state and next registered outputs; LO writes the low byte, HI the parked high byte.
    always_comb begin
        state_d   = WB_IDLE;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr;
        rf_data_d = rf_data;
        hi_addr_d = hi_addr_q;
        hi_data_d = hi_data_q;
        wide_d    = 1'b0;

        case (state_q)
            WB_LO: begin
                if (wide_q) begin
                    state_d   = WB_HI;
                    rf_we_d   = 1'b1;
                    rf_addr_d = hi_addr_q;
                    rf_data_d = hi_data_q;
                end else if (load_c) begin
                    state_d = WB_LO;
                end
            end
            default: begin
                if (load_c) begin
                    state_d = WB_LO;
                end
            end
        endcase

        // Wide results always target an even/odd pair, so rd[0] is dropped.
        if (state_d == WB_LO) begin
            rf_we_d   = 1'b1;
            rf_addr_d = {alu_rd_addr[REG_ADDR_W-1:1], alu_rd_addr[0] & ~alu_wide};
            rf_data_d = alu_out[BYTE_W-1:0];
            hi_addr_d = {alu_rd_addr[REG_ADDR_W-1:1], 1'b1};
            hi_data_d = alu_out[DATA_W-1:BYTE_W];
            wide_d    = alu_wide;
        end

        ready_d = ~((state_d == WB_LO) & wide_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WB_IDLE;
            alu_ready <= 1'b1;
            rf_we     <= 1'b0;
            rf_addr   <= '0;
            rf_data   <= '0;
            hi_addr_q <= '0;
            hi_data_q <= '0;
            wide_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_ready <= ready_d;
            rf_we     <= rf_we_d;
            rf_addr   <= rf_addr_d;
            rf_data   <= rf_data_d;
            hi_addr_q <= hi_addr_d;
            hi_data_q <= hi_data_d;
            wide_q    <= wide_d;
        end
    end

    mega_sreg #(
        .SREG_RST (SREG_RST)
    ) u_sreg (
        .clk       (clk),
        .rst       (rst),
        .io_we     (io_sreg_we),
        .io_wdata  (io_sreg_wdata),
        .alu_we    (accept_c & alu_flag_wr),
        .alu_flags (alu_flags),
        .int_ack   (int_ack),
        .reti      (reti),
        .sreg      (sreg)
    );

endmodule

// File: tb/tb_mega_alu_wb.sv
// Self-checking bench for mega_alu_wb: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the writeback stage.
module tb_mega_alu_wb;

    localparam logic [7:0] RST_VAL = 8'h5A;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd_addr;
    logic [15:0] alu_out;
    logic        alu_wide;
    logic        alu_wr_rd;
    logic        alu_flag_wr;
    logic [7:0]  alu_flags;
    logic        io_sreg_we;
    logic [7:0]  io_sreg_wdata;
    logic        int_ack;
    logic        reti;
    logic [7:0]  sreg;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [7:0]  rf_data;

    int checks;
    int failures;

    mega_alu_wb #(
        .REG_ADDR_W (5),
        .SREG_RST   (RST_VAL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd_addr   (alu_rd_addr),
        .alu_out       (alu_out),
        .alu_wide      (alu_wide),
        .alu_wr_rd     (alu_wr_rd),
        .alu_flag_wr   (alu_flag_wr),
        .alu_flags     (alu_flags),
        .io_sreg_we    (io_sreg_we),
        .io_sreg_wdata (io_sreg_wdata),
        .int_ack       (int_ack),
        .reti          (reti),
        .sreg          (sreg),
        .rf_we         (rf_we),
        .rf_addr       (rf_addr),
        .rf_data       (rf_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_in();
        alu_valid     = 1'b0;
        alu_rd_addr   = '0;
        alu_out       = '0;
        alu_wide      = 1'b0;
        alu_wr_rd     = 1'b0;
        alu_flag_wr   = 1'b0;
        alu_flags     = '0;
        io_sreg_we    = 1'b0;
        io_sreg_wdata = '0;
        int_ack       = 1'b0;
        reti          = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [15:0] o, input logic w,
                             input logic wr, input logic fw, input logic [7:0] f);
        alu_valid   = 1'b1;
        alu_rd_addr = rd;
        alu_out     = o;
        alu_wide    = w;
        alu_wr_rd   = wr;
        alu_flag_wr = fw;
        alu_flags   = f;
    endtask

    // Tasks below start and end on a falling edge with inputs idle.
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({rf_we, rf_addr, rf_data} !== 14'd0) begin
            failures++;
            $display("FAIL reset_rf got=%b/%h/%h exp=0/00/00", rf_we, rf_addr, rf_data);
        end
        checks++;
        if (sreg !== RST_VAL) begin
            failures++;
            $display("FAIL reset_sreg got=%h exp=%h", sreg, RST_VAL);
        end
        checks++;
        if (alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", alu_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_narrow();
        drive_alu(5'd5, 16'h003C, 1'b0, 1'b1, 1'b1, 8'h02);
        @(negedge clk);
        clear_in();
        checks++;
        if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd5, 8'h3C}) begin
            failures++;
            $display("FAIL narrow_wr got=%b/%0d/%h exp=1/5/3c", rf_we, rf_addr, rf_data);
        end
        checks++;
        if (sreg !== 8'h02) begin
            failures++;
            $display("FAIL narrow_sreg got=%h exp=02", sreg);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0) begin
            failures++;
            $display("FAIL narrow_single got=%b exp=0", rf_we);
        end
    endtask

    task automatic test_wide_back_to_back();
        drive_alu(5'd24, 16'h1234, 1'b1, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        checks++;
        if ({rf_we, rf_addr, rf_data, alu_ready} !== {1'b1, 5'd24, 8'h34, 1'b0}) begin
            failures++;
            $display("FAIL wide_lo got=%b/%0d/%h rdy=%b exp=1/24/34 rdy=0", rf_we, rf_addr, rf_data, alu_ready);
        end
        // Second result offered while stalled; must wait and its flags must not commit yet.
        drive_alu(5'd3, 16'h0055, 1'b0, 1'b1, 1'b1, 8'hAA);
        @(negedge clk);
        checks++;
        if ({rf_we, rf_addr, rf_data, alu_ready} !== {1'b1, 5'd25, 8'h12, 1'b1}) begin
            failures++;
            $display("FAIL wide_hi got=%b/%0d/%h rdy=%b exp=1/25/12 rdy=1", rf_we, rf_addr, rf_data, alu_ready);
        end
        checks++;
        if (sreg !== 8'h02) begin
            failures++;
            $display("FAIL held_no_flags got=%h exp=02", sreg);
        end
        @(negedge clk);
        clear_in();
        checks++;
        if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd3, 8'h55}) begin
            failures++;
            $display("FAIL held_accept got=%b/%0d/%h exp=1/3/55", rf_we, rf_addr, rf_data);
        end
        checks++;
        if (sreg !== 8'hAA) begin
            failures++;
            $display("FAIL held_flags got=%h exp=aa", sreg);
        end
        @(negedge clk);
    endtask

    task automatic test_mul_pairs();
        for (int i = 0; i < 2; i++) begin
            logic [4:0] rd;
            logic [4:0] ev;
            rd = (i == 0) ? 5'd0 : 5'd7;
            ev = (i == 0) ? 5'd0 : 5'd6;
            drive_alu(rd, 16'hFFFE, 1'b1, 1'b1, 1'b0, 8'h00);
            @(negedge clk);
            clear_in();
            checks++;
            if ({rf_we, rf_addr, rf_data} !== {1'b1, ev, 8'hFE}) begin
                failures++;
                $display("FAIL mul_lo rd=%0d got=%b/%0d/%h exp=1/%0d/fe", rd, rf_we, rf_addr, rf_data, ev);
            end
            @(negedge clk);
            checks++;
            if ({rf_we, rf_addr, rf_data} !== {1'b1, ev + 5'd1, 8'hFF}) begin
                failures++;
                $display("FAIL mul_hi rd=%0d got=%b/%0d/%h exp=1/%0d/ff", rd, rf_we, rf_addr, rf_data, ev + 5'd1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_compare_only();
        drive_alu(5'd9, 16'h00AB, 1'b0, 1'b0, 1'b1, 8'h01);
        @(negedge clk);
        clear_in();
        checks++;
        if (rf_we !== 1'b0) begin
            failures++;
            $display("FAIL cp_no_write got=%b exp=0", rf_we);
        end
        checks++;
        if (sreg !== 8'h01) begin
            failures++;
            $display("FAIL cp_sreg got=%h exp=01", sreg);
        end
    endtask

    task automatic test_sreg_priority();
        drive_alu(5'd2, 16'h0011, 1'b0, 1'b1, 1'b1, 8'h03);
        io_sreg_we    = 1'b1;
        io_sreg_wdata = 8'h80;
        int_ack       = 1'b1;
        @(negedge clk);
        clear_in();
        checks++;
        if (sreg !== 8'h00) begin
            failures++;
            $display("FAIL prio_io_intack got=%h exp=00", sreg);
        end
        checks++;
        if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd2, 8'h11}) begin
            failures++;
            $display("FAIL prio_rf got=%b/%0d/%h exp=1/2/11", rf_we, rf_addr, rf_data);
        end
        reti = 1'b1;
        @(negedge clk);
        reti = 1'b0;
        checks++;
        if (sreg !== 8'h80) begin
            failures++;
            $display("FAIL prio_reti got=%h exp=80", sreg);
        end
    endtask

    // Phase 0 resets while the low byte is out, phase 1 while the high byte is out.
    task automatic test_reset_mid_wide();
        for (int phase = 0; phase < 2; phase++) begin
            drive_alu(5'd10, 16'hBEEF, 1'b1, 1'b1, 1'b1, 8'h1F);
            @(negedge clk);
            clear_in();
            checks++;
            if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd10, 8'hEF}) begin
                failures++;
                $display("FAIL rstw_lo ph=%0d got=%b/%0d/%h exp=1/10/ef", phase, rf_we, rf_addr, rf_data);
            end
            if (phase == 1) begin
                @(negedge clk);
                checks++;
                if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd11, 8'hBE}) begin
                    failures++;
                    $display("FAIL rstw_hi got=%b/%0d/%h exp=1/11/be", rf_we, rf_addr, rf_data);
                end
            end
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            checks++;
            if ({rf_we, sreg, alu_ready} !== {1'b0, RST_VAL, 1'b1}) begin
                failures++;
                $display("FAIL rstw_after ph=%0d got we=%b sreg=%h rdy=%b exp we=0 sreg=%h rdy=1",
                         phase, rf_we, sreg, alu_ready, RST_VAL);
            end
            @(negedge clk);
            checks++;
            if (rf_we !== 1'b0) begin
                failures++;
                $display("FAIL rstw_late ph=%0d got=%b exp=0", phase, rf_we);
            end
        end
    endtask

    // Model: a queue-like pair of scheduled byte writes (this cycle, next cycle) and an SREG value.
    task automatic test_random();
        logic [7:0] m_sreg;
        logic       cur_v, nxt_v, rdy, acc;
        logic [4:0] cur_a, nxt_a, base;
        logic [7:0] cur_d, nxt_d;
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        m_sreg = RST_VAL;
        cur_v  = 1'b0;
        nxt_v  = 1'b0;
        cur_a  = '0;
        cur_d  = '0;
        nxt_a  = '0;
        nxt_d  = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            checks++;
            if (alu_ready !== !nxt_v) begin
                failures++;
                $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, alu_ready, !nxt_v);
            end
            checks++;
            if (rf_we !== cur_v || (cur_v && (rf_addr !== cur_a || rf_data !== cur_d))) begin
                failures++;
                $display("FAIL rnd_rf cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, rf_we, rf_addr, rf_data,
                         cur_v, cur_a, cur_d);
            end
            checks++;
            if (sreg !== m_sreg) begin
                failures++;
                $display("FAIL rnd_sreg cyc=%0d got=%h exp=%h", cyc, sreg, m_sreg);
            end

            rdy = !nxt_v;
            if (!(alu_valid && !rdy)) begin
                alu_valid   = ($urandom_range(0, 3) != 0);
                alu_rd_addr = 5'($urandom_range(0, 31));
                alu_out     = 16'($urandom);
                alu_wide    = 1'($urandom_range(0, 1));
                alu_wr_rd   = ($urandom_range(0, 4) != 0);
                alu_flag_wr = 1'($urandom_range(0, 1));
                alu_flags   = 8'($urandom);
            end
            io_sreg_we    = ($urandom_range(0, 7) == 0);
            io_sreg_wdata = 8'($urandom);
            int_ack       = ($urandom_range(0, 9) == 0);
            reti          = ($urandom_range(0, 9) == 0);
            rst           = ($urandom_range(0, 59) == 0);

            acc = alu_valid && rdy;
            if (rst) begin
                m_sreg = RST_VAL;
                cur_v  = 1'b0;
                nxt_v  = 1'b0;
            end else begin
                if (io_sreg_we) m_sreg = io_sreg_wdata;
                else if (acc && alu_flag_wr) m_sreg = alu_flags;
                if (int_ack) m_sreg[7] = 1'b0;
                else if (reti) m_sreg[7] = 1'b1;

                if (nxt_v) begin
                    cur_v = 1'b1;
                    cur_a = nxt_a;
                    cur_d = nxt_d;
                    nxt_v = 1'b0;
                end else if (acc && alu_wr_rd) begin
                    base  = alu_wide ? (alu_rd_addr & 5'h1E) : alu_rd_addr;
                    cur_v = 1'b1;
                    cur_a = base;
                    cur_d = alu_out[7:0];
                    nxt_v = alu_wide;
                    nxt_a = (alu_rd_addr & 5'h1E) + 5'd1;
                    nxt_d = alu_out[15:8];
                end else begin
                    cur_v = 1'b0;
                end
            end
            @(negedge clk);
        end
        rst = 1'b0;
        clear_in();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clear_in();
        test_reset();
        test_narrow();
        test_wide_back_to_back();
        test_mul_pairs();
        test_compare_only();
        test_sreg_priority();
        test_reset_mid_wide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
